timer_tick_sel: RTL and testbench
=================================

Name: timer_tick_sel

Overview:
Parametrised successor to the two-input timer clock select. It takes NSRC asynchronous slow tick sources, synchronises them into the single system clock, and picks one with a glitch-safe registered select. The chosen source's rising edges drive a loadable down-counter with one-shot and auto-reload modes. It sits between free-running reference sources (RTC, divided clocks, external pins) and timer consumers, and it replaces direct clock muxing with clean single-cycle tick strobes.

Parameters:
NSRC, 4, number of tick sources.
SEL_W, 2, select width; must satisfy 2^SEL_W >= NSRC.
CNT_W, 16, counter and load-value width.

Ports:
clk  in  1  system clock; every flop in the block is on this clock.
rst_n  in  1  asynchronous active-low reset.
src_in  in  NSRC  asynchronous tick sources; each high and low phase lasts >= 3 clk periods.
sel  in  SEL_W  source select; clk-synchronous.
start  in  1  single-cycle pulse: capture load_val and run.
stop  in  1  single-cycle pulse: halt the counter.
load_val  in  CNT_W  reload value, sampled only on start.
auto_reload  in  1  1 = periodic mode, 0 = one-shot; sampled on start.
tick_out  out  1  one-cycle strobe per accepted rising edge of the selected source.
count  out  CNT_W  current counter value.
running  out  1  high while in RUN.
expire  out  1  one-cycle pulse when the count reaches 0.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset: all flops clear. tick_out=0, count=0, running=0, expire=0, sel_q=0, blank=0, state=IDLE.
- Sync: each src_in bit passes through 2 flops (s1, s2), then a third flop s3. rise[i] = s2[i] & ~s3[i].
- Latency from a src_in rising edge to a rise[i] pulse is 2-3 clk edges.
- Select path:
  - sel_q is loaded from sel every cycle.
  - When sel != sel_q, a 2-bit blank counter is set to 2. It decrements to 0 on following cycles.
  - tick_int = rise[sel_q] & (blank==0) & (sel_q < NSRC).
  - Net effect: the first two cycles after a select change produce no ticks.
  - An out-of-range select yields no ticks.
- tick_out is tick_int registered, so it is asserted one edge after tick_int.
- The counter updates on that same edge, so count and tick_out change together.
- FSM has two states, IDLE and RUN. running = (state==RUN).
- IDLE:
  - start with load_val != 0: count <= load_val, reload_q <= load_val, mode_q <= auto_reload, go to RUN.
  - start with load_val == 0: expire=1 on the next edge, count stays 0, remain in IDLE.
  - Ticks in IDLE are still emitted on tick_out but do not change count.
- RUN, on tick_int:
  - count > 1: count <= count-1.
  - count == 1: expire pulses on the same edge.
    - mode_q=1: count <= reload_q, stay in RUN.
    - mode_q=0: count <= 0, go to IDLE.
- RUN, stop: go to IDLE; count holds its value; no expire.
- RUN, start: restart, i.e. reload from load_val and resample auto_reload.
- Priority within one cycle: stop > start > tick. A start coinciding with a final tick restarts the count and suppresses expire.
- sel changes while in RUN are legal. The count holds through blanking and resumes on ticks from the new source.
- Arithmetic: count never wraps below 0. reload_q and count are CNT_W wide, unsigned.
- Assertion of rst_n mid-operation takes effect immediately, asynchronously. Deassertion must be synchronised upstream.

Test Plan:
- Reset, then a 10-cycle-period square wave on src_in[2] with sel=2 -> exactly one tick_out pulse per source period. First tick_out arrives 3-4 clk after the source rises.
- sel=1, load_val=3, auto_reload=0, start -> count goes 3,2,1,0 on successive ticks. expire pulses with the transition to 0. running falls on that edge and no further decrement follows.
- auto_reload=1, load_val=2 -> count sequence 2,1,2,1... with expire on each 1->2 reload. Over 6 ticks, exactly 3 expire pulses.
- While running, change sel 0->3 on the same cycle src_in[3] rises -> no tick_out for 2 cycles. Ticks then come only from src_in[3]; count is unchanged during blanking.
- sel=5 with NSRC=4 (SEL_W=3 build) -> tick_out stays 0 and count frozen. start with load_val=0 -> single expire pulse while running stays 0.
- start and stop in the same cycle during RUN -> IDLE, count held. rst_n pulsed low mid-count (count=7) -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/timer_tick_sel.sv
// Timer tick source selector: synchronises NSRC slow tick sources, picks one via a
// blanked registered select, and drives a loadable one-shot / auto-reload down-counter.
module timer_tick_sel #(
  parameter int NSRC  = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NSRC-1:0]  src_in,
  input  logic [SEL_W-1:0] sel,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] load_val,
  input  logic             auto_reload,
  output logic             tick_out,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             expire
);

  localparam int unsigned NSEL = 2 ** SEL_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [NSRC-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [1:0]       blank_q, blank_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             expire_q, expire_d;
  logic [NSEL-1:0]  rise_ext;
  logic             tick_int;

  // Rise vector is zero-extended to the full select range so out-of-range selects see no ticks.
  always_comb begin
    s1_d  = src_in;
    s2_d  = s1_q;
    s3_d  = s2_q;
    sel_d = sel;
    rise_ext = '0;
    rise_ext[NSRC-1:0] = s2_q & ~s3_q;
    if (sel != sel_q) begin
      blank_d = 2'd2;
    end else if (blank_q != 2'd0) begin
      blank_d = blank_q - 2'd1;
    end else begin
      blank_d = 2'd0;
    end
    tick_int = rise_ext[sel_q] & (blank_q == 2'd0);
    tick_d   = tick_int;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      sel_q    <= '0;
      blank_q  <= '0;
      tick_q   <= 1'b0;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      sel_q    <= sel_d;
      blank_q  <= blank_d;
      tick_q   <= tick_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
    end
  end

  // Next state: stop beats start, start beats a tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    expire_d = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      if (load_val != '0) begin
        count_d  = load_val;
        reload_d = load_val;
        mode_d   = auto_reload;
        state_d  = RUN;
      end else begin
        count_d  = '0;
        expire_d = 1'b1;
        state_d  = IDLE;
      end
    end else if ((state_q == RUN) && tick_int) begin
      if (count_q > CNT_W'(1)) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        expire_d = 1'b1;
        if (mode_q) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    tick_out = tick_q;
    count    = count_q;
    running  = (state_q == RUN);
    expire   = expire_q;
  end

endmodule

// File: tb/tb_timer_tick_sel.sv
// Bench for timer_tick_sel: directed scenarios with literal expectations plus a long
// randomized run, all compared every cycle against a behavioural model.
module tb_timer_tick_sel;

  localparam int NSRC  = 4;
  localparam int SEL_W = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NSRC-1:0]  src_in = '0;
  logic [SEL_W-1:0] sel = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic             auto_reload = 1'b0;
  logic             tick_out;
  logic [CNT_W-1:0] count;
  logic             running;
  logic             expire;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  timer_tick_sel #(.NSRC(NSRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .src_in(src_in), .sel(sel), .start(start), .stop(stop),
    .load_val(load_val), .auto_reload(auto_reload), .tick_out(tick_out), .count(count),
    .running(running), .expire(expire)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a tick is accepted when the selected source (in range) showed a
  // 0->1 step two/three samples ago and the select has been steady for three samples.
  int m_count = 0, m_reload = 0, m_rise = 0;
  bit m_run = 0, m_mode = 0, m_exp = 0, m_tick = 0, m_tk = 0;
  int shist[3] = '{0, 0, 0};
  int selh[3]  = '{0, 0, 0};

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_count = 0; m_reload = 0; m_run = 0; m_mode = 0; m_exp = 0; m_tick = 0;
      shist = '{0, 0, 0};
      selh  = '{0, 0, 0};
    end else begin
      m_rise = shist[1] & ~shist[2];
      m_tk = (selh[0] == selh[1]) && (selh[1] == selh[2]) && (selh[0] < NSRC)
             && (((m_rise >> selh[0]) & 1) != 0);
      shist[2] = shist[1]; shist[1] = shist[0]; shist[0] = int'(src_in);
      selh[2]  = selh[1];  selh[1]  = selh[0];  selh[0]  = int'(sel);
      m_tick = m_tk;
      m_exp  = 0;
      if (stop) begin
        m_run = 0;
      end else if (start) begin
        if (load_val != 0) begin
          m_count = int'(load_val); m_reload = int'(load_val); m_mode = auto_reload; m_run = 1;
        end else begin
          m_count = 0; m_run = 0; m_exp = 1;
        end
      end else if (m_run && m_tk) begin
        if (m_count > 1) m_count = m_count - 1;
        else begin
          m_exp = 1;
          if (m_mode) m_count = m_reload;
          else begin m_count = 0; m_run = 0; end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      n_checks++;
      if (tick_out === m_tick && count === CNT_W'(m_count) && running === m_run && expire === m_exp)
        n_pass++;
      else
        $display("FAIL model_cmp at %0t: dut tick=%b cnt=%0d run=%b exp=%b, model tick=%b cnt=%0d run=%b exp=%b",
                 $time, tick_out, count, running, expire, m_tick, m_count, m_run, m_exp);
    end
  end

  // Source generator: each enabled source toggles after its phase count expires.
  int half[NSRC] = '{0, 0, 0, 0};
  int cnt[NSRC]  = '{0, 0, 0, 0};
  bit rnd_len = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #2;
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (half[i] != 0) begin
        if (cnt[i] <= 1) begin
          src_in[i] = ~src_in[i];
          cnt[i] = rnd_len ? int'($urandom_range(3, 8)) : half[i];
        end else cnt[i]--;
      end
    end
  endtask

  int exp_c1[4] = '{2, 1, 0, 0};
  int exp_e1[4] = '{0, 0, 1, 0};
  int exp_r1[4] = '{1, 1, 0, 0};
  int exp_c2[6] = '{1, 2, 1, 2, 1, 2};
  int qc[$], qe[$], qr[$];
  int tk, nt, nexp, guard, c0, r;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_count", count, 0);
    check("reset_running", running, 0);
    check("reset_tick", tick_out, 0);
    check("reset_expire", expire, 0);

    // One tick per source period, latency 3 edges from rise
    sel = 3'd2;
    repeat (5) cyc();
    src_in[2] = 1'b1; half[2] = 5; cnt[2] = 5;
    cyc(); cyc();
    check("lat_early", tick_out, 0);
    cyc();
    check("lat_first", tick_out, 1);
    tk = 1;
    repeat (47) begin cyc(); if (tick_out) tk++; end
    check("period_ticks", tk, 5);
    half[2] = 0; src_in[2] = 1'b0;

    // One-shot 3,2,1,0
    sel = 3'd1;
    repeat (4) cyc();
    half[1] = 4; cnt[1] = 1;
    load_val = 16'd3; auto_reload = 1'b0; start = 1'b1;
    cyc();
    check("oneshot_load", count, 3);
    check("oneshot_run", running, 1);
    repeat (40) begin
      cyc();
      if (tick_out) begin qc.push_back(int'(count)); qe.push_back(int'(expire)); qr.push_back(int'(running)); end
    end
    check("oneshot_nticks_ge4", qc.size() >= 4, 1);
    if (qc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("oneshot_count", qc[i], exp_c1[i]);
        check("oneshot_expire", qe[i], exp_e1[i]);
        check("oneshot_running", qr[i], exp_r1[i]);
      end
    end
    check("oneshot_hold", count, 0);

    // Auto-reload 2,1,2,1...
    load_val = 16'd2; auto_reload = 1'b1; start = 1'b1;
    cyc();
    check("auto_load", count, 2);
    qc.delete(); nt = 0; nexp = 0; guard = 0;
    while (nt < 6 && guard < 200) begin
      cyc(); guard++;
      if (tick_out) begin qc.push_back(int'(count)); nt++; if (expire) nexp++; end
    end
    check("auto_ticks", nt, 6);
    check("auto_expires", nexp, 3);
    for (int i = 0; i < qc.size() && i < 6; i++) check("auto_count", qc[i], exp_c2[i]);

    // Select change 0->3 coinciding with a src_in[3] rise
    half[1] = 0; src_in[1] = 1'b0; sel = 3'd0;
    repeat (6) cyc();
    check("blank_pre_run", running, 1);
    c0 = m_count;
    sel = 3'd3; src_in[3] = 1'b1; half[3] = 4; cnt[3] = 4;
    repeat (4) begin
      cyc();
      check("blank_tick", tick_out, 0);
      check("blank_count", count, c0);
    end
    nt = 0; guard = 0;
    while (nt == 0 && guard < 20) begin cyc(); guard++; if (tick_out) nt = 1; end
    check("newsrc_tick", nt, 1);
    check("newsrc_count", count, (c0 == 1) ? 2 : c0 - 1);
    half[3] = 0; src_in[3] = 1'b0;

    // Out-of-range select
    sel = 3'd5; load_val = 16'd9; auto_reload = 1'b0; start = 1'b1;
    cyc();
    rnd_len = 1'b1;
    for (int i = 0; i < NSRC; i++) begin half[i] = 1; cnt[i] = 0; end
    nt = 0;
    repeat (30) begin cyc(); if (tick_out) nt++; end
    check("oor_ticks", nt, 0);
    check("oor_count", count, 9);
    stop = 1'b1;
    cyc();
    check("oor_stop_run", running, 0);
    check("oor_stop_count", count, 9);
    load_val = 16'd0; start = 1'b1;
    cyc();
    check("zero_expire", expire, 1);
    check("zero_running", running, 0);
    check("zero_count", count, 0);
    cyc();
    check("zero_expire_once", expire, 0);

    // start+stop together during RUN
    sel = 3'd1;
    repeat (4) cyc();
    load_val = 16'd20; start = 1'b1;
    cyc();
    repeat (20) cyc();
    check("ss_pre_run", running, 1);
    c0 = m_count;
    start = 1'b1; stop = 1'b1; load_val = 16'd5;
    cyc();
    check("ss_running", running, 0);
    check("ss_count", count, c0);

    // Asynchronous reset mid-count
    load_val = 16'd7; start = 1'b1;
    cyc();
    check("arst_pre_count", count, 7);
    #1 rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_running", running, 0);
    check("arst_tick", tick_out, 0);
    check("arst_expire", expire, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Randomized run
    repeat (3000) begin
      cyc();
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        start = 1'b1;
        load_val = CNT_W'($urandom_range(0, 6));
        auto_reload = 1'($urandom_range(0, 1));
      end else if (r < 5) begin
        stop = 1'b1;
      end else if (r == 5) begin
        start = 1'b1; stop = 1'b1;
      end
      if ($urandom_range(0, 59) == 0)
        sel = ($urandom_range(0, 4) == 0) ? SEL_W'($urandom_range(4, 7)) : SEL_W'($urandom_range(0, 3));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
